add_op: RTL and testbench

ADD_OP -- requirements
Module: add_op

---
 rtl/add_op.sv | 166 ++++++++++++++++
 tb/tb_add_op.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/add_op.sv
// Single-precision floating-point adder with one register stage on the outputs.
// Denormals flush to zero; rounding is round-to-nearest-even on guard/round/sticky.
module add_op (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] para1,
    input  logic [31:0] para2,
    output logic [31:0] out,
    output logic        out_valid,
    output logic        under_overflow
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [31:0]        out_q, out_d;
    logic               vld_q, vld_d;
    logic               uf_q, uf_d;

    logic [31:0]        res;
    logic               res_flag;

    logic               sa, sb, sl, ss;
    logic [7:0]         ea, eb, el, es, ediff;
    logic [22:0]        fa, fb;
    logic [23:0]        ml, ms;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_big;
    logic [49:0]        sh_ext;
    logic [26:0]        big27, small27, diff27, norm27;
    logic [27:0]        sum28;
    logic [4:0]         lz;
    logic signed [9:0]  exp_n, exp_f;
    logic [24:0]        rnd;
    logic [22:0]        frac_f;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

    // v = {mantissa[23:0], guard, round, sticky}; bit 24 of the result is the carry-out.
    function automatic logic [24:0] round_rne(input logic [26:0] v);
        logic up;
        up = v[2] & (v[1] | v[0] | v[3]);
        return {1'b0, v[26:3]} + {24'd0, up};
    endfunction

    // Returns {flag, word}: saturates to infinity or flushes to zero when out of range.
    function automatic logic [32:0] pack_finite(input logic sign,
                                                input logic signed [9:0] e,
                                                input logic [22:0] frac);
        if (e >= 10'sd255)
            return {1'b1, sign, 8'hFF, 23'd0};
        else if (e <= 10'sd0)
            return {1'b1, sign, 31'd0};
        else
            return {1'b0, sign, e[7:0], frac};
    endfunction

    always_comb begin
        sa     = para1[31];
        ea     = para1[30:23];
        fa     = para1[22:0];
        sb     = para2[31];
        eb     = para2[30:23];
        fb     = para2[22:0];
        a_nan  = (ea == 8'hFF) && (fa != 23'd0);
        b_nan  = (eb == 8'hFF) && (fb != 23'd0);
        a_inf  = (ea == 8'hFF) && (fa == 23'd0);
        b_inf  = (eb == 8'hFF) && (fb == 23'd0);
        a_zero = (ea == 8'd0);
        b_zero = (eb == 8'd0);

        // Order by magnitude so the datapath only ever subtracts smaller from larger.
        a_big = {ea, fa} >= {eb, fb};
        if (a_big) begin
            sl = sa; el = ea; ml = {|ea, fa};
            ss = sb; es = eb; ms = {|eb, fb};
        end else begin
            sl = sb; el = eb; ml = {|eb, fb};
            ss = sa; es = ea; ms = {|ea, fa};
        end

        ediff   = el - es;
        big27   = {ml, 3'b000};
        sh_ext  = {ms, 26'd0} >> ediff;
        small27 = (ediff >= 8'd26) ? 27'd1 : {sh_ext[49:24], |sh_ext[23:0]};

        sum28  = {1'b0, big27} + {1'b0, small27};
        diff27 = big27 - small27;
        lz     = lzc27(diff27);
        exp_n  = signed'({2'b00, el});

        if (sl == ss) begin
            if (sum28[27]) begin
                norm27 = {sum28[27:2], sum28[1] | sum28[0]};
                exp_n  = exp_n + 10'sd1;
            end else begin
                norm27 = sum28[26:0];
            end
        end else begin
            norm27 = diff27 << lz;
            exp_n  = exp_n - signed'({5'b00000, lz});
        end

        rnd = round_rne(norm27);
        if (rnd[24]) begin
            frac_f = rnd[23:1];
            exp_f  = exp_n + 10'sd1;
        end else begin
            frac_f = rnd[22:0];
            exp_f  = exp_n;
        end

        {res_flag, res} = pack_finite(sl, exp_f, frac_f);

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            res = QNAN;         res_flag = 1'b0;
        end else if (a_inf) begin
            res = para1;        res_flag = 1'b0;
        end else if (b_inf) begin
            res = para2;        res_flag = 1'b0;
        end else if (a_zero && b_zero) begin
            res = {sa & sb, 31'd0}; res_flag = 1'b0;
        end else if (a_zero) begin
            res = para2;        res_flag = 1'b0;
        end else if (b_zero) begin
            res = para1;        res_flag = 1'b0;
        end else if ((sl != ss) && (diff27 == 27'd0)) begin
            res = 32'd0;        res_flag = 1'b0;
        end
    end

    always_comb begin
        out_d = out_q;
        uf_d  = uf_q;
        vld_d = 1'b0;
        if (in_valid) begin
            out_d = res;
            uf_d  = res_flag;
            vld_d = 1'b1;
        end
    end

    // output register stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= 32'd0;
            vld_q <= 1'b0;
            uf_q  <= 1'b0;
        end else begin
            out_q <= out_d;
            vld_q <= vld_d;
            uf_q  <= uf_d;
        end
    end

    assign out            = out_q;
    assign out_valid      = vld_q;
    assign under_overflow = uf_q;

endmodule

// File: tb/tb_add_op.sv
// Bench for add_op: directed vectors, randomized operands against an exact-arithmetic
// reference model, streaming, hold behaviour and asynchronous reset.
module tb_add_op;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] para1, para2;
    logic [31:0] out;
    logic        out_valid;
    logic        under_overflow;

    int          checks;
    int          errors;
    logic [31:0] last_out;
    logic        last_flag;

    add_op dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .para1          (para1),
        .para2          (para2),
        .out            (out),
        .out_valid      (out_valid),
        .under_overflow (under_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Exact sum on a wide integer grid, then a single correct RNE rounding.
    function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic         sa, sb, s;
        int           ea, eb, emin, p, sh, be;
        logic [287:0] ma, mb, mag, q, rem, half;
        sa = a[31]; sb = b[31];
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0))
            return {1'b0, 32'h7FC00000};
        if (ea == 255 && eb == 255)
            return (sa == sb) ? {1'b0, a} : {1'b0, 32'h7FC00000};
        if (ea == 255) return {1'b0, a};
        if (eb == 255) return {1'b0, b};
        if (ea == 0 && eb == 0) return {1'b0, sa & sb, 31'd0};
        if (ea == 0) return {1'b0, b};
        if (eb == 0) return {1'b0, a};
        emin = (ea < eb) ? ea : eb;
        ma = {264'd0, 1'b1, a[22:0]};
        mb = {264'd0, 1'b1, b[22:0]};
        ma = ma << (ea - emin);
        mb = mb << (eb - emin);
        if (sa == sb) begin
            mag = ma + mb; s = sa;
        end else if (ma > mb) begin
            mag = ma - mb; s = sa;
        end else if (mb > ma) begin
            mag = mb - ma; s = sb;
        end else begin
            return 33'd0;
        end
        p = 0;
        for (int i = 0; i < 288; i++) if (mag[i]) p = i;
        be = emin + p - 23;
        if (p > 23) begin
            sh   = p - 23;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = 288'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 288'd1;
            if (q[24]) begin
                q = q >> 1;
                be++;
            end
        end else begin
            q = mag << (23 - p);
        end
        if (be >= 255) return {1'b1, s, 8'hFF, 23'd0};
        if (be <= 0)   return {1'b1, s, 31'd0};
        return {1'b0, s, 8'(be), q[22:0]};
    endfunction

    function automatic logic [7:0] clamp_exp(input int e);
        if (e < 1) return 8'd1;
        if (e > 254) return 8'd254;
        return 8'(e);
    endfunction

    function automatic logic [31:0] rand_special();
        logic [31:0] tbl [8];
        tbl = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                32'h7FC12345, 32'h00412345, 32'h7F7FFFFF, 32'h00800000};
        return tbl[$urandom_range(0, 7)];
    endfunction

    function automatic logic [31:0] rand_op(input logic [31:0] ref_op);
        int       sel, e;
        logic [31:0] r;
        sel = int'($urandom_range(0, 9));
        r   = $urandom;
        case (sel)
            0:       r = rand_special();
            1, 2, 3: begin
                e = int'(ref_op[30:23]) + int'($urandom_range(0, 6)) - 3;
                r[30:23] = clamp_exp(e);
                if (sel == 1) r[22:0] = ref_op[22:0] ^ 23'($urandom_range(0, 3));
            end
            4:       r[30:23] = 8'($urandom_range(1, 4));
            5:       r[30:23] = 8'($urandom_range(250, 254));
            default: r[30:23] = 8'($urandom_range(1, 254));
        endcase
        return r;
    endfunction

    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eo, input logic ef, input string tag);
        @(negedge clk);
        in_valid = v;
        para1    = a;
        para2    = b;
        @(posedge clk);
        #1;
        check({tag, ".vld"}, {31'd0, out_valid}, {31'd0, v});
        if (v) begin
            last_out  = eo;
            last_flag = ef;
        end
        check(tag, out, last_out);
        check({tag, ".flag"}, {31'd0, under_overflow}, {31'd0, last_flag});
    endtask

    task automatic model_step(input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [32:0] r;
        r = ref_add(a, b);
        step(1'b1, a, b, r[31:0], r[32], tag);
    endtask

    initial begin
        logic [31:0] va [12];
        logic [31:0] vb [12];
        logic [31:0] vr [12];
        logic        vf [12];
        logic [31:0] a, b;

        va = '{32'h41480000, 32'h41A20000, 32'h41A20000, 32'hC1A20000, 32'hC1A20000,
               32'h4504D8B4, 32'h3F800000, 32'h3F800001, 32'h7F7FFFFF, 32'h00800001,
               32'h40400000, 32'h7F800000};
        vb = '{32'h40A80000, 32'h414C0000, 32'hC14C0000, 32'h414C0000, 32'hC14C0000,
               32'h461B13F8, 32'h33800000, 32'h33800000, 32'h7F7FFFFF, 32'h80800000,
               32'hC0400000, 32'hFF800000};
        vr = '{32'h418E0000, 32'h42040000, 32'h40F00000, 32'hC0F00000, 32'hC2040000,
               32'h463C4A25, 32'h3F800000, 32'h3F800002, 32'h7F800000, 32'h00000000,
               32'h00000000, 32'h7FC00000};
        vf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        checks    = 0;
        errors    = 0;
        clk       = 1'b0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        para1     = 32'd0;
        para2     = 32'd0;
        last_out  = 32'd0;
        last_flag = 1'b0;

        #2;
        check("rst.out", out, 32'd0);
        check("rst.vld", {31'd0, out_valid}, 32'd0);
        check("rst.flag", {31'd0, under_overflow}, 32'd0);

        @(negedge clk);
        rst = 1'b1;

        // Directed vectors streamed back to back, then both operand orders.
        for (int i = 0; i < 12; i++) step(1'b1, va[i], vb[i], vr[i], vf[i], $sformatf("dir%0d", i));
        for (int i = 0; i < 12; i++) step(1'b1, vb[i], va[i], vr[i], vf[i], $sformatf("swp%0d", i));
        step(1'b0, 32'h3F800000, 32'h3F800000, 32'd0, 1'b0, "idle");
        step(1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'd0, 1'b0, "idle2");

        model_step(32'h80000000, 32'h80000000, "negzero");
        model_step(32'h80000000, 32'h00000000, "mixzero");
        model_step(32'h00400000, 32'hBF800000, "ftz");
        model_step(32'h7F800000, 32'hC2000000, "inffin");
        model_step(32'hFFC00001, 32'h3F800000, "nan");

        for (int n = 0; n < 1500; n++) begin
            a = rand_op($urandom);
            b = rand_op(a);
            if ($urandom_range(0, 4) == 0)
                step(1'b0, a, b, 32'd0, 1'b0, "rgap");
            model_step(a, b, "rand");
            model_step(b, a, "rswap");
        end

        // Asynchronous reset between edges while a result is on the outputs.
        step(1'b1, 32'h41480000, 32'h40A80000, 32'h418E0000, 1'b0, "prerst");
        #2;
        rst = 1'b0;
        #1;
        check("arst.out", out, 32'd0);
        check("arst.vld", {31'd0, out_valid}, 32'd0);
        check("arst.flag", {31'd0, under_overflow}, 32'd0);
        @(negedge clk);
        in_valid = 1'b1;
        para1    = 32'h7F7FFFFF;
        para2    = 32'h7F7FFFFF;
        @(posedge clk);
        #1;
        check("inrst.out", out, 32'd0);
        check("inrst.vld", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        last_out  = 32'd0;
        last_flag = 1'b0;
        @(posedge clk);
        #1;
        check("postrst.vld", {31'd0, out_valid}, 32'd0);
        check("postrst.out", out, 32'd0);
        step(1'b1, 32'h41A20000, 32'hC14C0000, 32'h40F00000, 1'b0, "firstop");
        model_step(32'h3F800001, 32'h33800000, "after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
